// File: rtl/clock_div_switcher.sv
// clock_div_switcher: selectable integer clock divider with drained, gapped, glitch-free switching
module clock_div_switcher #(
  parameter int NUM_CLKS   = 3,
  parameter int CNT_W      = 4,
  parameter int SEL_W      = $clog2(NUM_CLKS + 1),
  parameter int GAP_CYCLES = 1,
  parameter int RESET_SEL  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CLKS*CNT_W-1:0] cfg_div,
  input  logic                      switch_val,
  output logic                      switch_rdy,
  input  logic [SEL_W-1:0]          switch_msg,
  output logic                      clk_div,
  output logic                      clk_en,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      switch_done
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, GAP = 2'd2, PARK = 2'd3;
  localparam logic [SEL_W-1:0] PARK_SEL = SEL_W'(NUM_CLKS);
  localparam logic [SEL_W-1:0] INIT_SEL = SEL_W'(RESET_SEL);
  logic [1:0] state, ns;
  logic [CNT_W-1:0] k, r, kk, r_raw, r_eff;
  logic [CNT_W:0] half;
  logic [3:0] gcnt;
  logic [SEL_W-1:0] nsel, m, tgt, new_sel, rsel;
  logic acc, sw, pend, leave, to_gap, run_nxt, last;
  // k holds the period index to present next; leaving a switch restarts it at 0
  always_comb begin
    m = switch_msg > PARK_SEL ? PARK_SEL : switch_msg;
    acc = switch_val & switch_rdy;
    sw = acc & (m != cur_sel);
    pend = (state == DRAIN) | (state == RUN & sw);
    tgt = state == DRAIN ? nsel : m;
    to_gap = (GAP_CYCLES != 0) & ((pend & k == '0) | (state == PARK & sw));
    leave = (state == GAP & gcnt == '0) | ((GAP_CYCLES == 0) & ((pend & k == '0) | (state == PARK & sw)));
    new_sel = state == GAP ? nsel : tgt;
    rsel = leave ? new_sel : cur_sel;
    kk = leave ? '0 : k;
    run_nxt = leave ? new_sel != PARK_SEL : (state == RUN | state == DRAIN) & !to_gap;
    r_raw = CNT_W'(1);
    for (int i = 0; i < NUM_CLKS; i++)
      if (rsel == SEL_W'(i)) r_raw = cfg_div[i*CNT_W +: CNT_W];
    r_eff = kk != '0 ? r : (r_raw == '0 ? CNT_W'(1) : r_raw);
    half = ({1'b0, r_eff} + 1'b1) >> 1;
    last = kk == r_eff - CNT_W'(1);
    ns = leave ? (new_sel == PARK_SEL ? PARK : RUN) : to_gap ? GAP :
         (state == GAP | state == PARK) ? state : pend ? DRAIN : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_SEL == PARK_SEL ? PARK : RUN;
      k <= '0;
      r <= CNT_W'(1);
      gcnt <= '0;
      nsel <= INIT_SEL;
      cur_sel <= INIT_SEL;
      clk_div <= 1'b0;
      clk_en <= 1'b0;
      switch_rdy <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state <= ns;
      clk_div <= run_nxt & ({1'b0, kk} < half);
      clk_en <= run_nxt & last;
      k <= (run_nxt & !last) ? kk + CNT_W'(1) : '0;
      r <= r_eff;
      gcnt <= to_gap ? 4'(GAP_CYCLES - 1) : (gcnt == '0 ? '0 : gcnt - 4'd1);
      if (state != GAP) nsel <= tgt;
      cur_sel <= rsel;
      switch_rdy <= ns == RUN | ns == PARK;
      switch_done <= leave | (acc & m == cur_sel);
    end
  end
endmodule
